alu_issue_decoder: RTL

Decode stage that feeds the ALU. Accepts fetched RV32I instructions over a valid/ready handshake and decodes opcode/funct3/funct7 into the ALU operation code, operand selects, immediate and register fields. Results go into a two-entry skid-buffered ID/EX register, so the stage runs at full throughput under execute-stage backpressure. Sits between instruction fetch and the execute stage that instantiates the ALU.

---
 rtl/alu_issue_decoder_pkg.sv | 76 +++++++
 rtl/alu_ctrl_decode.sv | 102 ++++++++++
 rtl/alu_issue_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_issue_decoder_pkg.sv
// Shared opcode, funct, ALU operation and operand-select constants for the ALU issue decoder.
// Build option ILLEGAL_FLAG_EN adds an illegal-encoding flag to each buffered entry.
package alu_issue_decoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;
  localparam logic [3:0] ALU_XXX    = 4'd15;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef struct packed {
    logic [3:0]  aluop;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
`ifdef ILLEGAL_FLAG_EN
    logic        illegal;
`endif
    logic [31:0] pc;
  } entry_t;

  // alt selects SUB/SRA; callers mask it for encodings where funct7[5] is meaningless.
  function automatic logic [3:0] alu_from_funct3(logic [2:0] funct3, logic alt);
    logic [3:0] op;
    case (funct3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I instruction to ALU control mapping (operation, operand selects, immediate).
// With ILLEGAL_FLAG_EN the illegal output reports unsupported encodings.
module alu_ctrl_decode
  import alu_issue_decoder_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  aluop,
  output logic        a_sel,
  output logic        b_sel,
  output logic [31:0] imm,
  output logic        reg_we
`ifdef ILLEGAL_FLAG_EN
  ,
  output logic        illegal
`endif
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    aluop  = ALU_XXX;
    a_sel  = A_SEL_RS1;
    b_sel  = B_SEL_RS2;
    imm    = '0;
    reg_we = 1'b0;
    case (opcode)
      OPC_OP: begin
        aluop  = alu_from_funct3(funct3, inst[30]);
        reg_we = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only SRAI uses funct7[5]; for ADDI it is part of the immediate.
        aluop  = alu_from_funct3(funct3, (funct3 == F3_SRL_SRA) && inst[30]);
        b_sel  = B_SEL_IMM;
        imm    = imm_i;
        reg_we = 1'b1;
      end
      OPC_LUI: begin
        aluop  = ALU_COPY_B;
        b_sel  = B_SEL_IMM;
        imm    = imm_u;
        reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        aluop  = ALU_ADD;
        a_sel  = A_SEL_PC;
        b_sel  = B_SEL_IMM;
        imm    = imm_u;
        reg_we = 1'b1;
      end
      OPC_LOAD: begin
        aluop  = ALU_ADD;
        b_sel  = B_SEL_IMM;
        imm    = imm_i;
        reg_we = 1'b1;
      end
      OPC_STORE: begin
        aluop = ALU_ADD;
        b_sel = B_SEL_IMM;
        imm   = imm_s;
      end
      OPC_BRANCH: begin
        aluop = ALU_ADD;
        a_sel = A_SEL_PC;
        b_sel = B_SEL_IMM;
        imm   = imm_b;
      end
      OPC_JAL: begin
        aluop  = ALU_ADD;
        a_sel  = A_SEL_PC;
        b_sel  = B_SEL_IMM;
        imm    = imm_j;
        reg_we = 1'b1;
      end
      OPC_JALR: begin
        aluop  = ALU_ADD;
        b_sel  = B_SEL_IMM;
        imm    = imm_i;
        reg_we = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_FLAG_EN
  // Every legal opcode yields a defined ALU op, so ALU_XXX marks the unknown ones.
  assign illegal = (aluop == ALU_XXX) ||
                   ((opcode == OPC_OP) && (inst[31:25] != F7_BASE) && (inst[31:25] != F7_ALT));
`endif

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode stage feeding the ALU: valid/ready input, decoder, and a two-entry skid-buffered ID/EX
// register with synchronous flush. Build option ILLEGAL_FLAG_EN adds the out_illegal port.
module alu_issue_decoder
  import alu_issue_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_aluop,
  output logic        out_a_sel,
  output logic        out_b_sel,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_reg_we,
  output logic [31:0] out_pc
`ifdef ILLEGAL_FLAG_EN
  ,
  output logic        out_illegal
`endif
);

  entry_t out_q, out_d, skid_q, skid_d, new_entry;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   in_fire, out_free;

  logic [3:0]  dec_aluop;
  logic        dec_a_sel, dec_b_sel, dec_reg_we;
  logic [31:0] dec_imm;
`ifdef ILLEGAL_FLAG_EN
  logic        dec_illegal;
`endif

  alu_ctrl_decode u_decode (
    .inst    (in_inst),
    .aluop   (dec_aluop),
    .a_sel   (dec_a_sel),
    .b_sel   (dec_b_sel),
    .imm     (dec_imm),
    .reg_we  (dec_reg_we)
`ifdef ILLEGAL_FLAG_EN
    ,
    .illegal (dec_illegal)
`endif
  );

  always_comb begin
    new_entry        = '0;
    new_entry.aluop  = dec_aluop;
    new_entry.a_sel  = dec_a_sel;
    new_entry.b_sel  = dec_b_sel;
    new_entry.imm    = dec_imm;
    new_entry.rs1    = in_inst[19:15];
    new_entry.rs2    = in_inst[24:20];
    new_entry.rd     = in_inst[11:7];
    new_entry.reg_we = dec_reg_we;
`ifdef ILLEGAL_FLAG_EN
    new_entry.illegal = dec_illegal;
`endif
    new_entry.pc     = in_pc;
  end

  // Ready is a function of registered state and flush only, so no comb path from out_ready.
  assign in_ready = !skid_valid_q && !flush;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no new entry can arrive this cycle.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_aluop  = out_q.aluop;
  assign out_a_sel  = out_q.a_sel;
  assign out_b_sel  = out_q.b_sel;
  assign out_imm    = out_q.imm;
  assign out_rs1    = out_q.rs1;
  assign out_rs2    = out_q.rs2;
  assign out_rd     = out_q.rd;
  assign out_reg_we = out_q.reg_we;
  assign out_pc     = out_q.pc;
`ifdef ILLEGAL_FLAG_EN
  assign out_illegal = out_q.illegal;
`endif

endmodule
